// File: rtl/digital_clock_ctrl.sv
// Timekeeping controller: hh:mm:ss counters, divider gating and a RUN/SET_HOUR/SET_MIN mode FSM.
// Optional 12-hour display with PM flag when DIGITAL_CLOCK_CTRL_12H_EN is defined.
module digital_clock_ctrl #(
  parameter logic TICK_IGNORE_FIRST = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic       div_enable,
  output logic       div_clear,
  output logic [4:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic       pm,
  output logic [1:0] mode
);

  // state       | meaning
  // ST_RUN      | time advances on tick_in, divider enabled
  // ST_SET_HOUR | btn_inc steps hours, divider stopped
  // ST_SET_MIN  | btn_inc steps minutes, divider stopped
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_SET_HOUR = 2'd1,
    ST_SET_MIN  = 2'd2
  } state_t;

`ifdef DIGITAL_CLOCK_CTRL_12H_EN
  localparam logic [4:0] HOUR_RST = 5'd12;
`else
  localparam logic [4:0] HOUR_RST = 5'd0;
`endif

  state_t     state_q, state_d;
  logic [4:0] hours_d, hour_nx;
  logic [5:0] minutes_d, seconds_d;
  logic       pm_d, pm_nx;
  logic       div_enable_d, div_clear_d;
  logic       ign_q, ign_d;
  logic       tick_eff, inc_eff, enter_set, exit_set;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:      if (btn_mode) state_d = ST_SET_HOUR;
      ST_SET_HOUR: if (btn_mode) state_d = ST_SET_MIN;
      ST_SET_MIN:  if (btn_mode) state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Shared hour successor for both the running carry and the set-hour button.
  always_comb begin
    hour_nx = hours + 5'd1;
    pm_nx   = pm;
`ifdef DIGITAL_CLOCK_CTRL_12H_EN
    if (hours == 5'd11) begin
      hour_nx = 5'd12;
      pm_nx   = ~pm;
    end else if (hours == 5'd12) begin
      hour_nx = 5'd1;
    end
`else
    pm_nx = 1'b0;
    if (hours == 5'd23) hour_nx = 5'd0;
`endif
  end

  always_comb begin
    tick_eff     = (state_q == ST_RUN) && tick_in && !ign_q;
    inc_eff      = btn_inc && !btn_mode;
    enter_set    = (state_q == ST_RUN) && btn_mode;
    exit_set     = (state_q == ST_SET_MIN) && btn_mode;
    hours_d      = hours;
    minutes_d    = minutes;
    seconds_d    = seconds;
    pm_d         = pm;
    ign_d        = ign_q;
    div_enable_d = (state_d == ST_RUN);
    div_clear_d  = exit_set;

    if (tick_eff) begin
      if (seconds == 6'd59) begin
        seconds_d = 6'd0;
        if (minutes == 6'd59) begin
          minutes_d = 6'd0;
          hours_d   = hour_nx;
          pm_d      = pm_nx;
        end else begin
          minutes_d = minutes + 6'd1;
        end
      end else begin
        seconds_d = seconds + 6'd1;
      end
    end

    if (inc_eff && (state_q == ST_SET_HOUR)) begin
      hours_d = hour_nx;
      pm_d    = pm_nx;
    end
    if (inc_eff && (state_q == ST_SET_MIN)) begin
      minutes_d = (minutes == 6'd59) ? 6'd0 : minutes + 6'd1;
    end

    // A tick coinciding with btn_mode is applied first; entry then zeroes seconds.
    if (enter_set || exit_set) seconds_d = 6'd0;

    if ((state_q == ST_RUN) && tick_in) ign_d = 1'b0;
    if (enter_set) ign_d = 1'b0;
    if (exit_set)  ign_d = TICK_IGNORE_FIRST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hours      <= HOUR_RST;
      minutes    <= 6'd0;
      seconds    <= 6'd0;
      pm         <= 1'b0;
      div_enable <= 1'b1;
      div_clear  <= 1'b0;
      ign_q      <= 1'b0;
    end else begin
      hours      <= hours_d;
      minutes    <= minutes_d;
      seconds    <= seconds_d;
      pm         <= pm_d;
      div_enable <= div_enable_d;
      div_clear  <= div_clear_d;
      ign_q      <= ign_d;
    end
  end

  assign mode = state_q;

endmodule

// File: tb/tb_digital_clock_ctrl.sv
// Directed bench for digital_clock_ctrl; expected outputs come from a seconds-of-day model
// pushed to a scoreboard when each step is driven and compared one cycle later.
module tb_digital_clock_ctrl;

  logic       clk = 1'b0;
  logic       rst, tick_in, btn_mode, btn_inc;
  logic       div_enable, div_clear, pm;
  logic [4:0] hours;
  logic [5:0] minutes, seconds;
  logic [1:0] mode;

  digital_clock_ctrl #(.TICK_IGNORE_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .tick_in(tick_in), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .div_enable(div_enable), .div_clear(div_clear), .hours(hours), .minutes(minutes),
    .seconds(seconds), .pm(pm), .mode(mode)
  );

  always #5 clk = ~clk;

`ifdef DIGITAL_CLOCK_CTRL_12H_EN
  localparam int H_RST = 12;
`else
  localparam int H_RST = 0;
`endif

  typedef struct packed {
    logic [1:0] mode;
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       pm;
    logic       en;
    logic       clr;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   t  = 0;   // model time, seconds of day (24h)
  int   md = 0;   // model mode

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t model_out(input logic clr);
    exp_t e;
    int h24;
    h24 = t / 3600;
`ifdef DIGITAL_CLOCK_CTRL_12H_EN
    e.h  = 5'(((h24 % 12) == 0) ? 12 : (h24 % 12));
    e.pm = (h24 >= 12);
`else
    e.h  = 5'(h24);
    e.pm = 1'b0;
`endif
    e.m    = 6'((t / 60) % 60);
    e.s    = 6'(t % 60);
    e.mode = 2'(md);
    e.en   = (md == 0);
    e.clr  = clr;
    return e;
  endfunction

  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_mode"},    32'(mode),       32'(e.mode));
    check({tag, "_hours"},   32'(hours),      32'(e.h));
    check({tag, "_minutes"}, 32'(minutes),    32'(e.m));
    check({tag, "_seconds"}, 32'(seconds),    32'(e.s));
    check({tag, "_pm"},      32'(pm),         32'(e.pm));
    check({tag, "_div_en"},  32'(div_enable), 32'(e.en));
    check({tag, "_div_clr"}, 32'(div_clear),  32'(e.clr));
  endtask

  task automatic step(input string tag, input logic bm, input logic bi, input logic tk);
    logic clr;
    int   h24, mm, ss;
    @(negedge clk);
    btn_mode = bm; btn_inc = bi; tick_in = tk;
    clr = (md == 2) && bm;
    if (md == 0 && tk) t = (t + 1) % 86400;
    if (bi && !bm) begin
      h24 = t / 3600; mm = (t / 60) % 60; ss = t % 60;
      if (md == 1) h24 = (h24 + 1) % 24;
      else if (md == 2) mm = (mm + 1) % 60;
      t = h24 * 3600 + mm * 60 + ss;
    end
    if (bm) begin
      md = (md + 1) % 3;
      if (md == 1 || md == 0) t = t - (t % 60);
    end
    sb.push_back(model_out(clr));
    @(posedge clk);
    #1;
    btn_mode = 1'b0; btn_inc = 1'b0; tick_in = 1'b0;
    compare_front(tag);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_mode"},    32'(mode),       32'd0);
    check({tag, "_hours"},   32'(hours),      32'(H_RST));
    check({tag, "_minutes"}, 32'(minutes),    32'd0);
    check({tag, "_seconds"}, 32'(seconds),    32'd0);
    check({tag, "_pm"},      32'(pm),         32'd0);
    check({tag, "_div_en"},  32'(div_enable), 32'd1);
    check({tag, "_div_clr"}, 32'(div_clear),  32'd0);
  endtask

  initial begin
    rst = 1'b1; tick_in = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 3; i++) step("run_tick", 1'b0, 1'b0, 1'b1);
    check("three_ticks_sec", 32'(seconds), 32'd3);
    step("run_inc_ignored", 1'b0, 1'b1, 1'b0);

    step("to_set_hour", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step("set_hour_inc", 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("set_hour_tick", 1'b0, 1'b0, 1'b1);

    step("mode_and_inc", 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 61; i++) step("set_min_inc", 1'b0, 1'b1, 1'b0);
    check("min_wrap_no_carry_h", 32'(hours), 32'd5);
    step("to_run", 1'b1, 1'b0, 1'b0);
    step("after_clear", 1'b0, 1'b0, 1'b1);

    // Preload 23:59 through set mode, then tick up to 23:59:58.
    step("to_set_hour2", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 24 && (t / 3600) != 23; i++) step("preload_h", 1'b0, 1'b1, 1'b0);
    step("to_set_min2", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 60 && ((t / 60) % 60) != 59; i++) step("preload_m", 1'b0, 1'b1, 1'b0);
    step("to_run2", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 58; i++) step("preload_s", 1'b0, 1'b0, 1'b1);
    step("tick_to_59", 1'b0, 1'b0, 1'b1);
    step("triple_carry", 1'b0, 1'b0, 1'b1);
    check("rollover_hours", 32'(hours), 32'(H_RST));
    check("rollover_min", 32'(minutes), 32'd0);
    check("rollover_sec", 32'(seconds), 32'd0);

    step("mode_with_tick", 1'b1, 1'b0, 1'b1);
    step("to_set_min3", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("set_min3_inc", 1'b0, 1'b1, 1'b0);

    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset("async_reset");
    @(posedge clk);
    #1;
    check_reset("held_reset");
    @(negedge clk);
    rst = 1'b0;
    t = 0; md = 0;

    // 12-step walk through the hour sequence from reset (12 AM -> 12 PM -> 1 PM in 12h builds).
    step("to_set_hour4", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) step("hour_walk", 1'b0, 1'b1, 1'b0);
`ifdef DIGITAL_CLOCK_CTRL_12H_EN
    check("noon_hours", 32'(hours), 32'd12);
    check("noon_pm", 32'(pm), 32'd1);
`endif
    step("hour_walk_13", 1'b0, 1'b1, 1'b0);
`ifdef DIGITAL_CLOCK_CTRL_12H_EN
    check("one_pm_hours", 32'(hours), 32'd1);
    check("one_pm_pm", 32'(pm), 32'd1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
